// File: rtl/store_commit_queue_if.sv
// store_commit_queue_if: issue, retire, memory-write and status signals of the store commit queue.
// The queue connects through the slave modport; its environment uses master.
interface store_commit_queue_if #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                     st_valid;
    logic [TAG_W-1:0]         st_tag;
    logic [ADDR_W-1:0]        st_addr;
    logic [DATA_W-1:0]        st_data;
    logic                     st_ready;
    logic                     retire_store_ready;
    logic [TAG_W-1:0]         retire_rd_tag;
    logic                     retire_store_ack;
    logic                     flush_valid;
    logic                     dmem_req;
    logic [ADDR_W-1:0]        dmem_addr;
    logic [DATA_W-1:0]        dmem_wdata;
    logic                     dmem_gnt;
    logic [$clog2(DEPTH):0]   sq_count;
    logic                     err_dup_tag;

    modport master (
        output st_valid, st_tag, st_addr, st_data, retire_store_ready, retire_rd_tag,
               flush_valid, dmem_gnt,
        input  st_ready, retire_store_ack, dmem_req, dmem_addr, dmem_wdata, sq_count, err_dup_tag
    );

    modport slave (
        input  st_valid, st_tag, st_addr, st_data, retire_store_ready, retire_rd_tag,
               flush_valid, dmem_gnt,
        output st_ready, retire_store_ack, dmem_req, dmem_addr, dmem_wdata, sq_count, err_dup_tag
    );
endinterface

// File: rtl/store_commit_queue.sv
// store_commit_queue: captures issued stores out of order by ROB tag and writes the ROB head
// store to data memory, acknowledging the retire once the write is granted.
module store_commit_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                 clock,
    input logic                 nreset,
    store_commit_queue_if.slave sq
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t            state;
    logic [DEPTH-1:0]  valid, valid_nx, keep_mask;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [IDX_W-1:0]  cur_idx, free_idx, dup_idx, match_idx, keep_idx, wr_idx;
    logic              dup_hit, match_hit, take, start, grant;
    logic              dmem_req, ack, err;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [CNT_W-1:0]  count;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        free_idx  = '0;
        dup_idx   = '0;
        match_idx = '0;
        dup_hit   = 1'b0;
        match_hit = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
            if (valid[i] && tag_q[i] == sq.st_tag) begin
                dup_hit = 1'b1;
                dup_idx = IDX_W'(i);
            end
            if (valid[i] && tag_q[i] == sq.retire_rd_tag) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(valid[i]);
    end

    assign take      = sq.st_valid && sq.st_ready && !sq.flush_valid;
    assign wr_idx    = dup_hit ? dup_idx : free_idx;
    assign start     = state == IDLE && sq.retire_store_ready && match_hit;
    assign grant     = state == REQ && sq.dmem_gnt;
    assign keep_idx  = start ? match_idx : cur_idx;
    // The entry being committed survives a flush; its write is already owed to the ROB.
    assign keep_mask = (state == REQ || start) ? DEPTH'(1) << keep_idx : '0;

    always_comb begin
        valid_nx = sq.flush_valid ? valid & keep_mask : valid;
        if (take) valid_nx[wr_idx] = 1'b1;
        if (grant) valid_nx[cur_idx] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (take) begin
            tag_q[wr_idx]  <= sq.st_tag;
            addr_q[wr_idx] <= sq.st_addr;
            data_q[wr_idx] <= sq.st_data;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            valid      <= '0;
            cur_idx    <= '0;
            dmem_req   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
        end else begin
            valid <= valid_nx;
            ack   <= grant;
            if (take && dup_hit) err <= 1'b1;
            if (start) begin
                state      <= REQ;
                cur_idx    <= match_idx;
                dmem_req   <= 1'b1;
                dmem_addr  <= addr_q[match_idx];
                dmem_wdata <= data_q[match_idx];
            end else if (grant) begin
                state    <= ACK;
                dmem_req <= 1'b0;
            end else if (state == ACK) begin
                state <= IDLE;
            end
        end
    end

    assign sq.st_ready         = ~&valid;
    assign sq.retire_store_ack = ack;
    assign sq.dmem_req         = dmem_req;
    assign sq.dmem_addr        = dmem_addr;
    assign sq.dmem_wdata       = dmem_wdata;
    assign sq.sq_count         = count;
    assign sq.err_dup_tag      = err;
endmodule

// File: tb/tb_store_commit_queue.sv
// tb_store_commit_queue: directed vectors with hand-computed expectations for store_commit_queue.
module tb_store_commit_queue;
    logic clock = 1'b0;
    logic nreset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    store_commit_queue_if #(.DEPTH(8), .TAG_W(5), .ADDR_W(32), .DATA_W(32)) sq ();

    store_commit_queue #(.DEPTH(8), .TAG_W(5), .ADDR_W(32), .DATA_W(32)) dut (
        .clock (clock),
        .nreset(nreset),
        .sq    (sq.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic issue(input logic [4:0] t, input logic [31:0] a, input logic [31:0] d);
        sq.st_valid = 1'b1;
        sq.st_tag   = t;
        sq.st_addr  = a;
        sq.st_data  = d;
        cyc();
        sq.st_valid = 1'b0;
    endtask

    // Head tag t retires; grant is withheld for wait_n cycles after the request appears.
    task automatic commit(input logic [4:0] t, input logic [31:0] a, input logic [31:0] d,
                          input int wait_n);
        sq.retire_store_ready = 1'b1;
        sq.retire_rd_tag      = t;
        cyc();
        for (int i = 0; i <= wait_n; i++) begin
            chk("req_high", sq.dmem_req, 1);
            chk("req_addr", sq.dmem_addr, a);
            chk("req_data", sq.dmem_wdata, d);
            chk("no_early_ack", sq.retire_store_ack, 0);
            if (i == wait_n) sq.dmem_gnt = 1'b1;
            cyc();
        end
        sq.dmem_gnt           = 1'b0;
        sq.retire_store_ready = 1'b0;
        chk("ack_pulse", sq.retire_store_ack, 1);
        chk("req_dropped", sq.dmem_req, 0);
        cyc();
        chk("ack_single", sq.retire_store_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sq.st_valid = 0; sq.st_tag = 0; sq.st_addr = 0; sq.st_data = 0;
        sq.retire_store_ready = 0; sq.retire_rd_tag = 0; sq.flush_valid = 0; sq.dmem_gnt = 0;
        cyc();
        cyc();
        chk("rst_st_ready", sq.st_ready, 1);
        chk("rst_ack", sq.retire_store_ack, 0);
        chk("rst_req", sq.dmem_req, 0);
        chk("rst_addr", sq.dmem_addr, 0);
        chk("rst_data", sq.dmem_wdata, 0);
        chk("rst_count", sq.sq_count, 0);
        chk("rst_err", sq.err_dup_tag, 0);
        nreset = 1'b1;
        cyc();

        // single store, minimum latency
        issue(5'd3, 32'h100, 32'hDEAD);
        chk("t1_count", sq.sq_count, 1);
        commit(5'd3, 32'h100, 32'hDEAD, 0);
        chk("t1_count_end", sq.sq_count, 0);

        // head not present: stay idle
        sq.retire_store_ready = 1'b1;
        sq.retire_rd_tag      = 5'd30;
        repeat (3) cyc();
        chk("nomatch_req", sq.dmem_req, 0);
        sq.retire_store_ready = 1'b0;

        // fill, overflow drop, free one
        for (int i = 0; i < 8; i++) issue(5'(i), 32'h200 + i, 32'hA000 + i);
        chk("full_ready", sq.st_ready, 0);
        chk("full_count", sq.sq_count, 8);
        issue(5'd8, 32'h2FF, 32'hBAD);
        chk("drop_count", sq.sq_count, 8);
        commit(5'd0, 32'h200, 32'hA000, 0);
        chk("freed_ready", sq.st_ready, 1);
        chk("freed_count", sq.sq_count, 7);
        sq.flush_valid = 1'b1;
        cyc();
        sq.flush_valid = 1'b0;
        chk("flush_idle_count", sq.sq_count, 0);

        // out-of-order issue, in-order commit
        issue(5'd5, 32'h505, 32'h5555);
        issue(5'd2, 32'h202, 32'h2222);
        chk("ooo_count", sq.sq_count, 2);
        commit(5'd2, 32'h202, 32'h2222, 0);
        chk("ooo_count_mid", sq.sq_count, 1);
        commit(5'd5, 32'h505, 32'h5555, 0);
        chk("ooo_count_end", sq.sq_count, 0);

        // grant held off for 10 cycles
        issue(5'd10, 32'h300, 32'hC0DE);
        commit(5'd10, 32'h300, 32'hC0DE, 10);
        chk("stall_count", sq.sq_count, 0);

        // flush with committed entry in flight and a simultaneous issue
        for (int i = 0; i < 7; i++) issue(5'(20 + i), 32'h400 + 20 + i, 32'h5000 + 20 + i);
        commit(5'd20, 32'h414, 32'h5014, 0);
        commit(5'd22, 32'h416, 32'h5016, 0);
        commit(5'd23, 32'h417, 32'h5017, 0);
        commit(5'd25, 32'h419, 32'h5019, 0);
        chk("t5_pre_count", sq.sq_count, 3);
        sq.retire_store_ready = 1'b1;
        sq.retire_rd_tag      = 5'd24;
        cyc();
        chk("t5_req", sq.dmem_req, 1);
        sq.flush_valid = 1'b1;
        sq.st_valid    = 1'b1;
        sq.st_tag      = 5'd9;
        sq.st_addr     = 32'h999;
        sq.st_data     = 32'h9999;
        cyc();
        sq.flush_valid = 1'b0;
        sq.st_valid    = 1'b0;
        chk("t5_flush_count", sq.sq_count, 1);
        chk("t5_req_kept", sq.dmem_req, 1);
        chk("t5_addr_kept", sq.dmem_addr, 32'h418);
        chk("t5_data_kept", sq.dmem_wdata, 32'h5018);
        sq.dmem_gnt = 1'b1;
        cyc();
        sq.dmem_gnt           = 1'b0;
        sq.retire_store_ready = 1'b0;
        chk("t5_ack", sq.retire_store_ack, 1);
        chk("t5_count_end", sq.sq_count, 0);
        cyc();
        chk("t5_ack_single", sq.retire_store_ack, 0);

        // duplicate tag
        chk("dup_err_pre", sq.err_dup_tag, 0);
        issue(5'd7, 32'h700, 32'h1111);
        issue(5'd7, 32'h704, 32'h2222);
        chk("dup_err", sq.err_dup_tag, 1);
        chk("dup_count", sq.sq_count, 1);
        commit(5'd7, 32'h704, 32'h2222, 0);
        chk("dup_count_end", sq.sq_count, 0);
        chk("dup_err_sticky", sq.err_dup_tag, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
